// File: rtl/tone_frame_decoder_pkg.sv
// tone_frame_decoder_pkg: shared state encoding, counter width and per-group tone defaults
package tone_frame_decoder_pkg;

    localparam int CNT_W = 16;

    localparam int G1_SYNC_MIN = 64;
    localparam int G1_TIMEOUT  = 4096;
    localparam int G2_SYNC_MIN = 64;
    localparam int G2_TIMEOUT  = 4096;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RECV = 2'd2
    } state_t;

    function automatic int group_sync_min(input int grp);
        return grp == 2 ? G2_SYNC_MIN : G1_SYNC_MIN;
    endfunction

    function automatic int group_timeout(input int grp);
        return grp == 2 ? G2_TIMEOUT : G1_TIMEOUT;
    endfunction

    // Counters stick at all-ones instead of wrapping back to zero
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return &v ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tone_frame_decoder_if.sv
// tone_frame_decoder_if: detector bits in, framed words out, for one tone group
interface tone_frame_decoder_if #(
    parameter int WORD_BITS = 8
);
    logic                 clk_enable;
    logic                 det_cmd;
    logic                 det_clk;
    logic                 det_sync;
    logic [WORD_BITS-1:0] word_out;
    logic                 word_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output clk_enable, det_cmd, det_clk, det_sync,
        input  word_out, word_valid, frame_err, busy
    );

    modport slave (
        input  clk_enable, det_cmd, det_clk, det_sync,
        output word_out, word_valid, frame_err, busy
    );
endinterface

// File: rtl/tone_edge_qualifier.sv
// tone_edge_qualifier: bit-clock rising-edge detect and sync-tone length qualification
module tone_edge_qualifier
    import tone_frame_decoder_pkg::*;
#(
    parameter int SYNC_MIN = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic det_clk,
    input  logic det_sync,
    output logic clk_rise,
    output logic sync_qual
);
    logic             det_clk_q;
    logic [CNT_W-1:0] sync_cnt;

    // Counting runs in every state, so an abort cycle in RECV already counts as the first sync cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            det_clk_q <= 1'b0;
            sync_cnt  <= '0;
        end else if (en) begin
            det_clk_q <= det_clk;
            sync_cnt  <= det_sync ? sat_inc(sync_cnt) : '0;
        end
    end

    assign clk_rise  = det_clk & ~det_clk_q;
    assign sync_qual = det_sync && sync_cnt == CNT_W'(SYNC_MIN - 1);
endmodule

// File: rtl/tone_frame_decoder.sv
// tone_frame_decoder: assembles sync-framed serial words from tone detector bits
module tone_frame_decoder
    import tone_frame_decoder_pkg::*;
#(
    parameter int GROUP     = 1,
    parameter int WORD_BITS = 8,
    parameter int SYNC_MIN  = group_sync_min(GROUP),
    parameter int TIMEOUT   = group_timeout(GROUP)
) (
    input logic                 clk,
    input logic                 reset,
    tone_frame_decoder_if.slave bus
);
    localparam int BW = $clog2(WORD_BITS + 1);

    state_t               state, state_nxt;
    logic [WORD_BITS-1:0] shift, shift_nxt, shifted;
    logic [WORD_BITS-1:0] word_q, word_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt, bit_cnt_inc;
    logic [CNT_W-1:0]     tmo_cnt, tmo_nxt;
    logic                 valid_q, valid_nxt, err_q, err_nxt, busy_q;
    logic                 clk_rise, sync_qual;

    tone_edge_qualifier #(.SYNC_MIN(SYNC_MIN)) u_qual (
        .clk      (clk),
        .reset    (reset),
        .en       (bus.clk_enable),
        .det_clk  (bus.det_clk),
        .det_sync (bus.det_sync),
        .clk_rise (clk_rise),
        .sync_qual(sync_qual)
    );

    assign shifted     = WORD_BITS'({shift, bus.det_cmd});
    assign bit_cnt_inc = bit_cnt + 1'b1;

    // Priority in RECV: sync abort, then bit edge, then timeout
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift;
        bit_cnt_nxt = bit_cnt;
        tmo_nxt     = tmo_cnt;
        word_nxt    = word_q;
        valid_nxt   = 1'b0;
        err_nxt     = 1'b0;
        case (state)
            IDLE: state_nxt = sync_qual ? SYNC : IDLE;
            SYNC: begin
                if (!bus.det_sync) begin
                    state_nxt   = RECV;
                    shift_nxt   = '0;
                    bit_cnt_nxt = '0;
                    tmo_nxt     = '0;
                end
            end
            RECV: begin
                if (bus.det_sync) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else if (clk_rise) begin
                    shift_nxt   = shifted;
                    bit_cnt_nxt = bit_cnt_inc;
                    tmo_nxt     = '0;
                    if (bit_cnt_inc == BW'(WORD_BITS)) begin
                        word_nxt  = shifted;
                        valid_nxt = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (tmo_cnt == CNT_W'(TIMEOUT - 1)) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    tmo_nxt = sat_inc(tmo_cnt);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tmo_cnt <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else if (bus.clk_enable) begin
            state   <= state_nxt;
            shift   <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            tmo_cnt <= tmo_nxt;
            word_q  <= word_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
            busy_q  <= state_nxt != IDLE;
        end
    end

    assign bus.word_out   = word_q;
    assign bus.word_valid = valid_q;
    assign bus.frame_err  = err_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/tone_frame_decoder.md
Name: tone_frame_decoder

Overview:
- Downstream of the tone detector: consumes the three per-group detector bits (command 3475/4240 Hz, bit-clock 5110/6205 Hz, sync 7395/8900 Hz) and assembles framed serial words.
- Sync tone opens a frame, bit-clock tone rising edges sample the command tone, and a complete word is presented with a valid strobe.
- Instantiated once per tone group (group 1 and group 2) beside the detector.

Parameters:
- WORD_BITS, 8, data bits per frame, range 1..16, MSB received first.
- SYNC_MIN, 64, minimum consecutive enabled cycles of det_sync high to qualify a sync, range 1..65535.
- TIMEOUT, 4096, maximum enabled cycles between bit-clock edges (and from sync release to first edge) before abort, range 1..65535.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- clk_enable  in  1  sample-rate enable; all state advances only when high
- det_cmd  in  1  command-tone detector bit (data)
- det_clk  in  1  bit-clock-tone detector bit
- det_sync  in  1  sync-tone detector bit
- word_out  out  WORD_BITS  last complete word, held until the next word completes
- word_valid  out  1  high for exactly one enabled cycle when word_out updates
- frame_err  out  1  high for one enabled cycle on timeout or sync abort
- busy  out  1  high in SYNC and RECV states

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; word_out=0, word_valid=0, frame_err=0, busy=0.
  - All counters and the shift register cleared; det_clk/det_sync history registers cleared to 0.
  - Reset mid-frame discards partial data; no error pulse is generated.
- clk_enable=0: all registers hold, including pulse outputs. A pulse therefore lasts until the next enabled cycle.
- Edge detect: clk_rise = det_clk & ~det_clk_q, where det_clk_q is updated on enabled cycles only.
- States:
  - IDLE: sync_cnt counts enabled cycles with det_sync=1 and resets to 0 when det_sync=0. When sync_cnt reaches SYNC_MIN-1 with det_sync=1, go to SYNC.
  - SYNC: wait for det_sync=0, then go to RECV. Clear bit_cnt, shift register, and tmo_cnt. clk_rise is ignored in SYNC.
  - RECV:
    - On clk_rise: shift = {shift[WORD_BITS-2:0], det_cmd} (det_cmd sampled in the same cycle as the edge); bit_cnt++; tmo_cnt=0.
    - Otherwise tmo_cnt++.
    - When bit_cnt reaches WORD_BITS on a clk_rise: word_out<=new shift value, word_valid=1 next cycle, go to IDLE.
    - If tmo_cnt reaches TIMEOUT-1 without a clk_rise: frame_err=1, go to IDLE.
    - If det_sync=1 in RECV: frame_err=1, go to IDLE with sync_cnt=1. The sync count restarts immediately and the abort is not lost.
  - Simultaneous events in RECV:
    - det_sync=1 together with clk_rise: sync abort wins and the bit is discarded.
    - clk_rise in the same cycle timeout would fire: the edge wins and tmo_cnt clears.
- Latency: word_valid asserts on the enabled cycle after the clk_rise carrying the last bit.
- Widths:
  - bit_cnt is clog2(WORD_BITS+1) bits.
  - sync_cnt and tmo_cnt are 16-bit unsigned and saturate; they never wrap.
- busy is a registered decode of state.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=0, SYNC=1, RECV=2, 2-bit);
  - counter width constant CNT_W=16;
  - group tone defaults (SYNC_MIN, TIMEOUT) for group 1 and group 2.
- Natural sub-module: tone_edge_qualifier, containing the det_clk rising-edge detector and the sync qualification counter.
- The frame FSM, shift register and timeout counter remain in tone_frame_decoder.

Test Plan:
1. det_sync high 64 enabled cycles then low; 8 det_clk pulses (10 high/10 low cycles each) with det_cmd=1,0,1,1,0,0,1,0 -> word_out=8'hB2, word_valid one cycle after 8th rising edge, frame_err=0.
2. det_sync high 63 cycles only, then clk pulses -> no state change, busy=0, no word_valid.
3. Valid sync, 3 bits, then det_clk held low 4096 cycles -> frame_err pulse exactly at cycle 4096 after last edge, word_out unchanged (previous 8'hB2).
4. Valid sync, 5 bits, det_sync reasserted for 64 cycles coincident with a clk_rise -> frame_err pulse, bit discarded; a new frame of 8'h5A then decodes correctly.
5. clk_enable toggled 1/0 every cycle during scenario 1 -> same word_out=8'hB2; word_valid held across the disabled cycle.
6. reset asserted after 4 bits -> all outputs 0 immediately (async); after release, a full frame 8'hFF decodes with no frame_err.
